restart_divider: RTL
====================

// Module: restart_divider
// PURPOSE
//  Parametrised programmable clock-enable divider with restart.
//  - Counts enabled clk cycles modulo a runtime divide value; emits a one-cycle tick at each wrap.
//  - Drives out either as a toggling square wave or as a registered pulse train.
//  - A rising edge on restart re-phases the counter and output immediately.
//  - Generalises the fixed divide-by-4 toggler used in earlier lab blocks.
// PARAMETERS
//  CNT_W        4  counter / divide-value width in bits (>=2)
//  DEFAULT_DIV  4  divide value loaded at reset (1..2^CNT_W-1)
// PORTS
//  clk      in   1      clock; all state updates on rising edge
//  rst      in   1      asynchronous reset, active-high
//  en       in   1      count enable; low = hold all state
//  restart  in   1      level input; its rising edge re-phases the block
//  mode     in   1      0 = toggle (square wave), 1 = pulse
//  div      in   CNT_W  divide value N; div==0 is treated as 1
//  out      out  1      divided output
//  tick     out  1      registered one-cycle wrap strobe
//  cnt      out  CNT_W  current phase count, 0..N-1
// BEHAVIOUR
//  - Reset (async, immediate): cnt=0, out=0, tick=0, div_q=DEFAULT_DIV, restart_q=0.
//  - div_q (internal): latched from div at reset release's first wrap, at every wrap and at every restart edge.
//    - div changes mid-period take effect from the next period only.
//  - Restart edge: rs = restart & ~restart_q; restart_q <= restart every edge, regardless of en.
//  - Per rising clk edge, first match wins:
//    1. rs=1: cnt<=0, out<=0, tick<=0, div_q<=div. Applies even when en=0.
//    2. en=0: cnt, div_q hold; tick<=0; out holds in mode 0; out<=0 in mode 1.
//    3. cnt==div_q-1 (wrap): cnt<=0, tick<=1, div_q<=div.
//       - Mode 0: out<=~out.
//       - Mode 1: out<=1.
//    4. Otherwise: cnt<=cnt+1 (CNT_W-bit, no overflow by construction), tick<=0.
//       - Mode 0: out holds.
//       - Mode 1: out<=0.
//  - Latency: with N=div_q, tick is high for exactly 1 cycle after every N enabled edges.
//    - Mode 0: out period is 2N enabled cycles.
//    - Mode 1: out is a copy of tick.
//  - N=1: wrap on every enabled edge.
//    - tick stays high continuously.
//    - Mode 0: out toggles every cycle.
//  - Mode change: takes effect at the next edge.
//    - Entering mode 1 forces out low unless that edge is a wrap.
//    - Entering mode 0 holds the current out.
//  - restart held high: only its first edge acts. restart high at reset release causes one restart on the first edge.
//  - Simultaneous wrap and restart edge: restart wins, and no tick is produced.
// CONFIGURATION
//  RESTART_SYNC_EN
//  - Defined: restart passes through a 2-flop synchroniser (reset to 0) before edge detect.
//    - Restart takes effect 2 cycles later than below.
//    - restart may be asynchronous to clk.
//  - Undefined: restart must be synchronous to clk; only the edge-detect flop is present.
//  - All test expectations below assume undefined; with the macro defined, shift restart responses +2 cycles.
// TESTING
//  - Reset then basic count: rst 1->0, en=1, mode=0, div=4.
//    -> cnt 0,1,2,3,0...; tick high 1 cycle after edges 4,8,12; out 0->1 at edge 4, 1->0 at edge 8.
//  - Pulse mode: mode=1, div=3.
//    -> out==tick; both high 1 cycle in every 3; never high 2 cycles in a row.
//  - Restart mid-period: div=5, cnt=3, then pulse restart.
//    -> next edge cnt=0, out=0, tick=0; next tick 5 edges later; holding restart high has no further effect.
//  - Enable gating: div=4, en low for 6 cycles at cnt=2.
//    -> cnt stays 2, tick stays 0, out holds (mode 0); resuming gives tick 2 edges later.
//  - Divide-value change and edges: div 4->2 at cnt=1.
//    -> current period completes at 4, then period 2.
//    - div=0 or div=1 -> tick constantly high, out toggling every cycle.
//  - Async reset mid-operation: assert rst between clk edges with cnt=3, out=1.
//    -> cnt=0, out=0, tick=0 immediately, before the next edge.
//    - Collision case: wrap edge coinciding with a restart edge -> no tick, cnt=0.

Source files
------------

// File: rtl/restart_divider.sv
// restart_divider: programmable clock-enable divider with restart.
// Counts enabled clk cycles modulo a runtime divide value and emits a one-cycle
// tick at each wrap. The out pin carries either a toggling square wave (mode 0)
// or a registered copy of the tick (mode 1). A rising edge on restart re-phases
// the counter and the output.
// Optional build macro: RESTART_SYNC_EN adds a 2-flop synchroniser on restart
// (restart may then be asynchronous; its response arrives 2 cycles later).
module restart_divider #(
    parameter int CNT_W       = 4,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             restart,
    input  logic             mode,
    input  logic [CNT_W-1:0] div,
    output logic             out,
    output logic             tick,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic             out_q, out_d;
    logic             tick_q, tick_d;
    logic             restart_q;
    logic             restart_s;
    logic             rs;
    logic             wrap;

    // A zero divide value would never wrap; treat it as divide-by-one.
    function automatic logic [CNT_W-1:0] sanitize_div(input logic [CNT_W-1:0] d);
        return (d == '0) ? ONE : d;
    endfunction

`ifdef RESTART_SYNC_EN
    logic sync1_q, sync2_q;

    // Two-flop synchroniser so restart may arrive from another clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= restart;
            sync2_q <= sync1_q;
        end
    end

    assign restart_s = sync2_q;
`else
    assign restart_s = restart;
`endif

    // Edge-detect history; updates every edge regardless of en so a held
    // restart only acts once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            restart_q <= 1'b0;
        end else begin
            restart_q <= restart_s;
        end
    end

    assign rs   = restart_s & ~restart_q;
    assign wrap = (cnt_q == (div_q - ONE));

    // Next-state selection: restart beats enable-hold beats wrap beats count.
    always_comb begin
        cnt_d  = cnt_q;
        div_d  = div_q;
        out_d  = out_q;
        tick_d = 1'b0;
        if (rs) begin
            cnt_d = '0;
            out_d = 1'b0;
            div_d = sanitize_div(div);
        end else if (!en) begin
            // Pulse output must not stretch while gated; square wave holds.
            if (mode) begin
                out_d = 1'b0;
            end
        end else if (wrap) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            div_d  = sanitize_div(div);
            out_d  = mode ? 1'b1 : ~out_q;
        end else begin
            cnt_d = cnt_q + ONE;
            if (mode) begin
                out_d = 1'b0;
            end
        end
    end

    // Divider state registers, cleared immediately by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            div_q  <= DIV_INIT;
            out_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            out_q  <= out_d;
            tick_q <= tick_d;
        end
    end

    assign cnt  = cnt_q;
    assign out  = out_q;
    assign tick = tick_q;

endmodule
